// File: rtl/seg7_display_mux_pkg.sv
// seg7_display_mux_pkg: shared display constants, hex segment table and clog2 helper
//   SEG_BLANK : all segments off (active-low)
//   AN_OFF    : all anodes off (active-low)
//   HEX_SEG   : active-low {g,f,e,d,c,b,a} codes for nibbles 0..F
//   clog2     : constant width helper, never returns less than 1
package seg7_display_mux_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/seg7_display_mux_if.sv
// seg7_display_mux_if: machine-to-display bus
//   data_in/load/blank : driven by the machine (master)
//   seg/dp/an          : active-low display pins driven by the display (slave)
interface seg7_display_mux_if;

    logic [7:0] data_in;
    logic       load;
    logic       blank;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    modport master (output data_in, load, blank, input seg, dp, an);
    modport slave  (input data_in, load, blank, output seg, dp, an);

endinterface

// File: rtl/seg7_display_mux_hex_to_seg7.sv
// hex_to_seg7: combinational nibble to active-low 7-segment code
//   i_nibble : 4-bit value
//   o_seg    : {g,f,e,d,c,b,a}, active-low
module hex_to_seg7
    import seg7_display_mux_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG[i_nibble];

endmodule

// File: rtl/seg7_display_mux.sv
// seg7_display_mux: 4-digit multiplexed hex display of current and previous byte with update flash
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of seg7_display_mux_if (data_in/load/blank in, seg/dp/an out)
module seg7_display_mux
    import seg7_display_mux_pkg::*;
#(
    parameter int CLK_DIV      = 50000,
    parameter int FLASH_CYCLES = 25000000
) (
    input logic               clk,
    input logic               rst,
    seg7_display_mux_if.slave bus
);

    localparam int DW = clog2(CLK_DIV);
    localparam int FW = clog2(FLASH_CYCLES + 1);

    logic [DW-1:0] r_div;
    logic [1:0]    r_sel;
    logic [7:0]    r_cur;
    logic [7:0]    r_prev;
    logic [FW-1:0] r_flash;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic [3:0]    r_an;
    logic          w_tick;
    logic [3:0]    w_nib;
    logic [6:0]    w_seg;

    assign w_tick = r_div == DW'(CLK_DIV - 1);
    // digits 1:0 show cur, digits 3:2 show prev; odd digits take the high nibble
    assign w_nib  = r_sel[1] ? (r_sel[0] ? r_prev[7:4] : r_prev[3:0])
                             : (r_sel[0] ? r_cur[7:4]  : r_cur[3:0]);

    hex_to_seg7 u_hex (.i_nibble(w_nib), .o_seg(w_seg));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div   <= '0;
            r_sel   <= '0;
            r_cur   <= '0;
            r_prev  <= '0;
            r_flash <= '0;
            r_seg   <= SEG_BLANK;
            r_dp    <= 1'b1;
            r_an    <= AN_OFF;
        end else begin
            r_div <= w_tick ? '0 : r_div + DW'(1);
            if (w_tick) r_sel <= r_sel + 2'd1;
            if (bus.load) begin
                r_prev  <= r_cur;
                r_cur   <= bus.data_in;
                r_flash <= FW'(FLASH_CYCLES);
            end else if (r_flash != '0) begin
                r_flash <= r_flash - FW'(1);
            end
            // outputs reflect pre-edge state, so a load shows up one edge later
            r_an  <= bus.blank ? AN_OFF : ~(4'b0001 << r_sel);
            r_seg <= bus.blank ? SEG_BLANK : w_seg;
            r_dp  <= bus.blank || r_sel != 2'd0 || r_flash == '0;
        end
    end

    assign bus.seg = r_seg;
    assign bus.dp  = r_dp;
    assign bus.an  = r_an;

endmodule
